// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared types for the universal shift register.
//   mode_t  : operation applied by one step of the register
//   state_t : burst engine state (IDLE accepts SHIFT/START, RUN steps a burst)
// ---------------------------------------------------------------------------
package shift_pkg;

    typedef enum logic [2:0] {
        HOLD  = 3'b000,
        SHR   = 3'b001,
        SHL   = 3'b010,
        ROR   = 3'b011,
        ROL   = 3'b100,
        LOAD  = 3'b101,
        ASR   = 3'b110,
        CLEAR = 3'b111
    } mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/shift_step.sv
// ---------------------------------------------------------------------------
// shift_step
// Purely combinational next-value function for one step of the register.
// Ports:
//   q          : current register contents
//   mode       : operation to apply
//   serial_in_r: bit entering the MSB on a right shift
//   serial_in_l: bit entering the LSB on a left shift
//   d          : parallel load data
//   q_next     : register contents after the step
// ---------------------------------------------------------------------------
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  mode_t            mode,
    input  logic             serial_in_r,
    input  logic             serial_in_l,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q_next
);

    always_comb begin
        q_next = q;
        case (mode)
            HOLD:    q_next = q;
            SHR:     q_next = {serial_in_r, q[WIDTH-1:1]};
            SHL:     q_next = {q[WIDTH-2:0], serial_in_l};
            ROR:     q_next = {q[0], q[WIDTH-1:1]};
            ROL:     q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            LOAD:    q_next = d;
            // Sign bit is replicated into the vacated MSB.
            ASR:     q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            CLEAR:   q_next = '0;
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// ---------------------------------------------------------------------------
// univ_shift_reg
// Universal shift register with single-step and counted-burst operation.
// Ports:
//   CLK        : rising-edge clock
//   CLR_N      : asynchronous active-low reset
//   SYNC_CLR   : synchronous clear, aborts any burst without a DONE
//   MODE       : operation select (see shift_pkg::mode_t)
//   SHIFT      : one step with live MODE, honoured in IDLE only
//   START      : begin a burst of COUNT steps, honoured in IDLE only
//   COUNT      : number of steps in the burst
//   SerialInR  : bit entering the MSB on right shift
//   SerialInL  : bit entering the LSB on left shift
//   D          : parallel load data, sampled live on every step
//   Q          : register contents
//   SerialOutR : Q[0]
//   SerialOutL : Q[WIDTH-1]
//   BUSY       : high while a burst is running
//   DONE       : one-cycle pulse after the final burst step
//   dbg_state  : current burst engine state (0 = IDLE, 1 = RUN)
//
// Burst handshake: START is accepted only when BUSY is low. When START is
// sampled with COUNT>0 at edge k, MODE is latched, BUSY rises after edge k,
// Q steps at edges k+1..k+COUNT, BUSY falls and DONE is high for exactly the
// cycle after edge k+COUNT. COUNT==0 produces only the DONE pulse. A new
// START may be presented while DONE is high.
// ---------------------------------------------------------------------------
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int  WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             SYNC_CLR,
    input  logic [2:0]       MODE,
    input  logic             SHIFT,
    input  logic             START,
    input  logic [CNT_W-1:0] COUNT,
    input  logic             SerialInR,
    input  logic             SerialInL,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             SerialOutR,
    output logic             SerialOutL,
    output logic             BUSY,
    output logic             DONE,
    output logic             dbg_state
);

    state_t           state;
    mode_t            mode_lat;
    logic [CNT_W-1:0] remaining;
    mode_t            step_mode;
    logic [WIDTH-1:0] q_next;

    // A single step unit serves both paths: live MODE for IDLE single steps,
    // the latched mode while a burst runs so MODE changes are ignored.
    assign step_mode = (state == RUN) ? mode_lat : mode_t'(MODE);

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q           (Q),
        .mode        (step_mode),
        .serial_in_r (SerialInR),
        .serial_in_l (SerialInL),
        .d           (D),
        .q_next      (q_next)
    );

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            Q         <= '0;
            state     <= IDLE;
            mode_lat  <= HOLD;
            remaining <= '0;
            DONE      <= 1'b0;
        end else if (SYNC_CLR) begin
            Q         <= '0;
            state     <= IDLE;
            remaining <= '0;
            DONE      <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                RUN: begin
                    Q         <= q_next;
                    remaining <= remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state <= IDLE;
                        DONE  <= 1'b1;
                    end
                end
                default: begin
                    if (START) begin
                        // START outranks SHIFT; Q is untouched on the accept edge.
                        if (COUNT != '0) begin
                            mode_lat  <= mode_t'(MODE);
                            remaining <= COUNT;
                            state     <= RUN;
                        end else begin
                            DONE <= 1'b1;
                        end
                    end else if (SHIFT) begin
                        Q <= q_next;
                    end
                end
            endcase
        end
    end

    assign BUSY       = (state == RUN);
    assign SerialOutR = Q[0];
    assign SerialOutL = Q[WIDTH-1];
    assign dbg_state  = state;

endmodule

// File: tb/tb_univ_shift_reg.sv
// ---------------------------------------------------------------------------
// tb_univ_shift_reg
// Directed bench for univ_shift_reg (WIDTH=4). A behavioural model computes
// each step with integer arithmetic and tracks the burst as a plain count of
// steps left; a compare process checks every output on each falling edge.
// Directed sequences additionally pin literal, hand-computed values.
// ---------------------------------------------------------------------------
module tb_univ_shift_reg;

    localparam int W     = 4;
    localparam int CW    = $clog2(W + 1);
    localparam int PW2   = 1 << W;
    localparam int MSBV  = 1 << (W - 1);

    localparam logic [2:0] M_HOLD  = 3'd0;
    localparam logic [2:0] M_SHR   = 3'd1;
    localparam logic [2:0] M_SHL   = 3'd2;
    localparam logic [2:0] M_ROR   = 3'd3;
    localparam logic [2:0] M_ROL   = 3'd4;
    localparam logic [2:0] M_LOAD  = 3'd5;
    localparam logic [2:0] M_ASR   = 3'd6;
    localparam logic [2:0] M_CLEAR = 3'd7;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          clr_n = 1'b0;
    logic          sync_clr = 1'b0;
    logic [2:0]    mode = M_HOLD;
    logic          shift = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] count = '0;
    logic          sir = 1'b0;
    logic          sil = 1'b0;
    logic [W-1:0]  d = '0;
    logic [W-1:0]  q;
    logic          sor, sol, busy, done, dbg_state;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(W)) dut (
        .CLK        (clk),
        .CLR_N      (clr_n),
        .SYNC_CLR   (sync_clr),
        .MODE       (mode),
        .SHIFT      (shift),
        .START      (start),
        .COUNT      (count),
        .SerialInR  (sir),
        .SerialInL  (sil),
        .D          (d),
        .Q          (q),
        .SerialOutR (sor),
        .SerialOutL (sol),
        .BUSY       (busy),
        .DONE       (done),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_q    = '0;
    int           m_left = 0;
    logic         m_done = 1'b0;
    logic [2:0]   m_mode = M_HOLD;

    function automatic int step(input int v, input logic [2:0] md, input logic r,
                                input logic l, input int dv);
        case (md)
            M_SHR:   return v / 2 + (r ? MSBV : 0);
            M_SHL:   return (v * 2) % PW2 + (l ? 1 : 0);
            M_ROR:   return v / 2 + (v % 2) * MSBV;
            M_ROL:   return (v * 2) % PW2 + v / MSBV;
            M_LOAD:  return dv;
            M_ASR:   return v / 2 + ((v >= MSBV) ? MSBV : 0);
            M_CLEAR: return 0;
            default: return v;
        endcase
    endfunction

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_q = '0; m_left = 0; m_done = 1'b0; m_mode = M_HOLD;
        end else begin
            m_done = 1'b0;
            if (sync_clr) begin
                m_q = '0; m_left = 0;
            end else if (m_left > 0) begin
                m_q = W'(step(int'(m_q), m_mode, sir, sil, int'(d)));
                m_left--;
                m_done = (m_left == 0);
            end else if (start) begin
                m_left = int'(count);
                m_mode = mode;
                m_done = (count == 0);
            end else if (shift) begin
                m_q = W'(step(int'(m_q), mode, sir, sil, int'(d)));
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            check("q",       32'(q),         32'(m_q));
            check("sor",     32'(sor),       32'(m_q[0]));
            check("sol",     32'(sol),       32'(m_q[W-1]));
            check("busy",    32'(busy),      32'(m_left > 0));
            check("done",    32'(done),      32'(m_done));
            check("state",   32'(dbg_state), 32'(m_left > 0));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input string name, input logic [W-1:0] exp_q,
                       input logic exp_busy, input logic exp_done);
        check({name, ".q"},    32'(q),    32'(exp_q));
        check({name, ".busy"}, 32'(busy), 32'(exp_busy));
        check({name, ".done"}, 32'(done), 32'(exp_done));
    endtask

    task automatic load(input logic [W-1:0] v);
        mode = M_LOAD; d = v; shift = 1'b1;
        tick();
        shift = 1'b0;
        check("load", 32'(q), 32'(v));
    endtask

    task automatic go(input logic [2:0] md, input int n);
        mode = md; count = CW'(n); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    logic [W-1:0] shr_exp [4] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
    logic [W-1:0] rol_exp [3] = '{4'b0011, 4'b0110, 4'b1100};

    initial begin
        #12;
        pin("reset", 4'b0000, 1'b0, 1'b0);
        clr_n = 1'b1;
        tick();
        cmp_en = 1'b1;

        // Single-step SHR, serial-in 1
        mode = M_SHR; sir = 1'b1; shift = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            pin("shr_step", shr_exp[i], 1'b0, 1'b0);
        end
        shift = 1'b0;

        // Rotate-left burst of 3
        load(4'b1001);
        go(M_ROL, 3);
        pin("rol_accept", 4'b1001, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            pin("rol_step", rol_exp[i], (i < 2), (i == 2));
        end
        tick();
        pin("rol_after", 4'b1100, 1'b0, 1'b0);

        // ASR burst of 2
        load(4'b1000);
        go(M_ASR, 2);
        tick();
        pin("asr1", 4'b1100, 1'b1, 1'b0);
        check("asr1.sor", 32'(sor), 32'd0);
        check("asr1.sol", 32'(sol), 32'd1);
        tick();
        pin("asr2", 4'b1110, 1'b0, 1'b1);
        check("asr2.sor", 32'(sor), 32'd0);
        check("asr2.sol", 32'(sol), 32'd1);

        // Abort by SYNC_CLR, with a START pulsed while busy
        mode = M_CLEAR; shift = 1'b1; tick(); shift = 1'b0;
        sir = 1'b1;
        go(M_SHR, 4);
        tick();
        pin("abort1", 4'b1000, 1'b1, 1'b0);
        start = 1'b1; count = CW'(4);
        tick();
        start = 1'b0;
        pin("abort2", 4'b1100, 1'b1, 1'b0);
        sync_clr = 1'b1;
        tick();
        sync_clr = 1'b0;
        pin("abort_clr", 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            pin("abort_idle", 4'b0000, 1'b0, 1'b0);
        end

        // START with COUNT=0
        load(4'b0101);
        go(M_SHR, 0);
        pin("cnt0", 4'b0101, 1'b0, 1'b1);
        tick();
        pin("cnt0_after", 4'b0101, 1'b0, 1'b0);

        // START+SHIFT together, MODE changed mid-burst
        sil = 1'b1; shift = 1'b1;
        go(M_SHL, 2);
        shift = 1'b0;
        pin("st_sh", 4'b0101, 1'b1, 1'b0);
        mode = M_CLEAR;
        tick();
        pin("latched1", 4'b1011, 1'b1, 1'b0);
        tick();
        pin("latched2", 4'b0111, 1'b0, 1'b1);

        // Back-to-back START while DONE is high
        go(M_ROR, 1);
        pin("b2b_accept", 4'b0111, 1'b1, 1'b0);
        tick();
        pin("b2b_step", 4'b1011, 1'b0, 1'b1);

        // COUNT > WIDTH: five rotations equal one
        go(M_ROR, 5);
        for (int i = 0; i < 5; i++) tick();
        pin("ror5", 4'b1101, 1'b0, 1'b1);
        tick();

        // Asynchronous reset mid-burst, between edges
        sir = 1'b1;
        go(M_SHR, 4);
        tick();
        @(posedge clk);
        #3 clr_n = 1'b0;
        #1 pin("async", 4'b0000, 1'b0, 1'b0);
        #2 clr_n = 1'b1;
        tick();
        pin("async_hold", 4'b0000, 1'b0, 1'b0);
        load(4'b1010);
        go(M_ROL, 1);
        tick();
        pin("resume", 4'b0101, 1'b0, 1'b1);

        // A few random single steps, checked by the model only
        for (int i = 0; i < 20; i++) begin
            mode  = 3'($urandom_range(0, 7));
            sir   = 1'($urandom_range(0, 1));
            sil   = 1'($urandom_range(0, 1));
            d     = W'($urandom_range(0, PW2 - 1));
            shift = 1'b1;
            tick();
        end
        shift = 1'b0;
        tick();

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
